// File: rtl/action_ram_acc.sv
// Action-value RAM: registered read port, write/accumulate pipeline, and a hardware clear sequencer.
// Define ACTION_RAM_SAT_EN to make accumulate overflow saturate instead of wrapping.
module action_ram_acc #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 18,
   parameter int                DEPTH    = 19683,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   output logic              busy,
   input  logic              write_enable,
   input  logic              write_accumulate,
   input  logic [ADDR_W-1:0] write_address,
   input  logic [DATA_W-1:0] d_in,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] read_address,
   output logic [DATA_W-1:0] d_out,
   output logic              d_valid,
   output logic              ovf
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_addr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_in_range;
   logic              rd_in_range;
   logic              wr_issue;
   logic              rd_issue;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   logic              s2_valid;
   logic              s2_acc;
   logic [IDX_W-1:0]  s2_idx;
   logic [DATA_W-1:0] s2_data;
   logic [DATA_W-1:0] s2_old;

   logic [DATA_W:0]   sum_ext;
   logic              sum_ovf;
   logic [DATA_W-1:0] acc_result;
   logic [DATA_W-1:0] s2_result;
   logic [DATA_W-1:0] wr_old;
   logic [DATA_W-1:0] rd_data;

   assign busy        = (state == CLEAR);
   assign wr_in_range = ({1'b0, write_address} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, read_address} < DEPTH_EXT);
   assign wr_idx      = write_address[IDX_W-1:0];
   assign rd_idx      = read_address[IDX_W-1:0];
   assign wr_issue    = !busy && write_enable && wr_in_range;
   assign rd_issue    = !busy && read_enable;

   // Stage-2 result; the sum is one bit wider so a signed overflow is visible as a sign disagreement.
   always_comb begin
      sum_ext    = {s2_old[DATA_W-1], s2_old} + {s2_data[DATA_W-1], s2_data};
      sum_ovf    = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
      acc_result = sum_ext[DATA_W-1:0];
`ifdef ACTION_RAM_SAT_EN
      if (sum_ovf) begin
         acc_result = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
      end
`endif
      s2_result = s2_acc ? acc_result : s2_data;
   end

   // The entry being committed this cycle is not yet in the array, so both ports bypass it.
   always_comb begin
      wr_old = mem[wr_idx];
      rd_data = mem[rd_idx];
      if (s2_valid && (s2_idx == wr_idx)) begin
         wr_old = s2_result;
      end
      if (s2_valid && (s2_idx == rd_idx)) begin
         rd_data = s2_result;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_acc   <= 1'b0;
         s2_idx   <= '0;
         s2_data  <= '0;
         s2_old   <= '0;
         ovf      <= 1'b0;
      end else begin
         s2_valid <= wr_issue;
         if (wr_issue) begin
            s2_acc  <= write_accumulate;
            s2_idx  <= wr_idx;
            s2_data <= d_in;
            s2_old  <= wr_old;
         end
         ovf <= s2_valid && s2_acc && sum_ovf;
      end
   end

   // Out-of-range reads still answer, with zero, so the selector never waits on a missing pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d_out   <= '0;
         d_valid <= 1'b0;
      end else begin
         d_valid <= rd_issue;
         if (rd_issue) begin
            d_out <= rd_in_range ? rd_data : '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end
            end
            CLEAR: begin
               if (clear) begin
                  clr_addr <= '0;
               end else if (clr_addr == LAST_IDX) begin
                  state    <= IDLE;
                  clr_addr <= '0;
               end else begin
                  clr_addr <= clr_addr + IDX_W'(1);
               end
            end
            default: begin
               state    <= CLEAR;
               clr_addr <= '0;
            end
         endcase
      end
   end

   // The clear write is last so it wins over a commit landing on the same entry.
   always_ff @(posedge clock) begin
      if (s2_valid) begin
         mem[s2_idx] <= s2_result;
      end
      if (state == CLEAR) begin
         mem[clr_addr] <= INIT_VAL;
      end
   end

endmodule

// File: tb/tb_action_ram_acc.sv
// Scoreboard bench for action_ram_acc with a 16-entry, 8-bit configuration.
// Expected reads are queued when issued and popped when d_valid appears.
module tb_action_ram_acc;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 16;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              clear = 1'b0;
   logic              busy;
   logic              write_enable = 1'b0;
   logic              write_accumulate = 1'b0;
   logic [ADDR_W-1:0] write_address = '0;
   logic [DATA_W-1:0] d_in = '0;
   logic              read_enable = 1'b0;
   logic [ADDR_W-1:0] read_address = '0;
   logic [DATA_W-1:0] d_out;
   logic              d_valid;
   logic              ovf;

   int vectors = 0;
   int miscompares = 0;
   int ovf_seen = 0;
   int ovf_expected = 0;
   int busy_left = 0;

   logic [DATA_W-1:0] exp_mem [DEPTH];
   logic [DATA_W-1:0] rd_queue [$];
   logic [DATA_W-1:0] exp_rd;

   action_ram_acc #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .INIT_VAL(8'd0)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .clear           (clear),
      .busy            (busy),
      .write_enable    (write_enable),
      .write_accumulate(write_accumulate),
      .write_address   (write_address),
      .d_in            (d_in),
      .read_enable     (read_enable),
      .read_address    (read_address),
      .d_out           (d_out),
      .d_valid         (d_valid),
      .ovf             (ovf)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Signed reference arithmetic done in plain integers.
   function automatic logic [DATA_W-1:0] model_acc(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                   output bit o);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      o = (s > 127) || (s < -128);
`ifdef ACTION_RAM_SAT_EN
      if (s > 127) return 8'h7F;
      if (s < -128) return 8'h80;
`endif
      return 8'(s);
   endfunction

   always @(negedge clock) begin
      if (reset_n && ovf === 1'b1) ovf_seen++;
      if (reset_n && d_valid === 1'b1) begin
         if (rd_queue.size() == 0) begin
            checkOutput("unexpected_d_valid", 32'(d_valid), 32'd0);
         end else begin
            exp_rd = rd_queue.pop_front();
            checkOutput("d_out", 32'(d_out), 32'(exp_rd));
         end
      end
   end

   // One cycle of requests; the model applies reads before the same cycle's write.
   task automatic applyStimulus(input int clr, input int we, input int acc, input int waddr, input int d,
                                input int re, input int raddr);
      bit o;
      @(posedge clock);
      #1;
      checkOutput("busy", 32'(busy), 32'(busy_left > 0));
      clear            = (clr != 0);
      write_enable     = (we != 0);
      write_accumulate = (acc != 0);
      write_address    = ADDR_W'(waddr);
      d_in             = DATA_W'(d);
      read_enable      = (re != 0);
      read_address     = ADDR_W'(raddr);
      if (busy_left > 0) begin
         busy_left--;
         if (clr != 0) busy_left = 16;
      end else begin
         if (re != 0) rd_queue.push_back((raddr < DEPTH) ? exp_mem[raddr] : 8'd0);
         if (we != 0 && waddr < DEPTH) begin
            if (acc != 0) begin
               exp_mem[waddr] = model_acc(exp_mem[waddr], DATA_W'(d), o);
               if (o) ovf_expected++;
            end else begin
               exp_mem[waddr] = DATA_W'(d);
            end
         end
         if (clr != 0) begin
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'd0;
            busy_left = 16;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic applyReset(input string tag);
      int n;
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      clear = 1'b0;
      write_enable = 1'b0;
      write_accumulate = 1'b0;
      read_enable = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput({tag, "_rst_d_out"}, 32'(d_out), 32'd0);
      checkOutput({tag, "_rst_d_valid"}, 32'(d_valid), 32'd0);
      checkOutput({tag, "_rst_ovf"}, 32'(ovf), 32'd0);
      checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd1);
      rd_queue.delete();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'd0;
      reset_n = 1'b1;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clock);
         #1;
      end
      checkOutput({tag, "_busy_cycles"}, 32'(n), 32'd16);
      busy_left = 0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'd0;
      applyReset("por");

      for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 0, 0, 1, a);
      idle(1);

      applyStimulus(0, 1, 0, 5, 12, 1, 5);
      applyStimulus(0, 0, 0, 0, 0, 1, 5);
      applyStimulus(0, 0, 0, 0, 0, 1, 5);

      applyStimulus(0, 1, 1, 3, 10, 0, 0);
      applyStimulus(0, 1, 1, 3, 20, 0, 0);
      applyStimulus(0, 1, 1, 3, -5, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 3);
      idle(3);
      checkOutput("ovf_after_acc3", 32'(ovf_seen), 32'(ovf_expected));

      applyStimulus(0, 1, 0, 7, 120, 0, 0);
      applyStimulus(0, 1, 1, 7, 10, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 7);
      idle(3);
      checkOutput("ovf_after_pos_ovf", 32'(ovf_seen), 32'(ovf_expected));

      applyStimulus(0, 1, 0, 8, 8'h80, 0, 0);
      applyStimulus(0, 1, 1, 8, 8'hFF, 0, 0);
      idle(1);
      applyStimulus(0, 0, 0, 0, 0, 1, 8);
      idle(3);
      checkOutput("ovf_after_neg_ovf", 32'(ovf_seen), 32'(ovf_expected));

      applyStimulus(0, 1, 0, 20, 9, 1, 4);
      applyStimulus(0, 1, 1, 21, 8'h7F, 1, 20);
      applyStimulus(0, 1, 1, 23, 8'h7F, 1, 4);
      applyStimulus(0, 0, 0, 0, 0, 1, 5);
      idle(3);
      checkOutput("ovf_out_of_range", 32'(ovf_seen), 32'(ovf_expected));

      applyStimulus(0, 1, 0, 9, 33, 1, 5);
      applyStimulus(0, 0, 0, 0, 0, 1, 9);
      idle(1);

      applyStimulus(0, 1, 0, 2, 50, 0, 0);
      applyStimulus(1, 1, 0, 6, 77, 1, 2);
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, i, 8'hAA, 1, i);
      applyStimulus(0, 0, 0, 0, 0, 1, 2);
      applyStimulus(0, 0, 0, 0, 0, 1, 6);
      applyStimulus(0, 0, 0, 0, 0, 1, 5);
      applyStimulus(0, 0, 0, 0, 0, 1, 9);

      applyStimulus(0, 1, 0, 11, 44, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      idle(4);
      applyStimulus(1, 1, 0, 1, 5, 1, 1);
      while (busy_left > 0) idle(1);
      applyStimulus(0, 0, 0, 0, 0, 1, 11);
      applyStimulus(0, 1, 0, 12, 66, 1, 12);
      applyStimulus(0, 0, 0, 0, 0, 1, 12);

      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      idle(5);
      applyReset("mid_clear");
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 15);
      applyStimulus(0, 0, 0, 0, 0, 1, 12);
      idle(3);

      checkOutput("rd_queue_empty", 32'(rd_queue.size()), 32'd0);
      checkOutput("ovf_total", 32'(ovf_seen), 32'(ovf_expected));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/action_ram_acc.md
Name: action_ram_acc

Overview:
- Parametrised successor to the tic-tac-toe action-value RAM: single clock, one write/accumulate port, one registered read port.
- Adds a signed read-modify-write accumulate mode for value updates and a hardware clear sequencer that initialises every entry.
- Adds out-of-range address handling.
- Sits between the learning/update controller (writes, accumulates) and the move-selection logic (reads).

Parameters:
DATA_W, 8, entry width; signed two's complement in accumulate mode
ADDR_W, 18, address width
DEPTH, 19683, number of entries (3^9 board states); must be <= 2^ADDR_W
INIT_VAL, 0, value written to every entry by the clear sequencer

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
clear  in  1  request a full-memory clear
busy  out  1  clear sequencer active; all requests ignored
write_enable  in  1  write request
write_accumulate  in  1  0 = overwrite with d_in; 1 = mem += d_in (signed)
write_address  in  ADDR_W  write/accumulate address
d_in  in  DATA_W  write data or signed delta
read_enable  in  1  read request
read_address  in  ADDR_W  read address
d_out  out  DATA_W  read data, registered
d_valid  out  1  one-cycle pulse: d_out updated this cycle
ovf  out  1  one-cycle pulse: an accumulate overflowed the signed range

Behaviour:
- Reset (asynchronous): d_out=0, d_valid=0, ovf=0; write pipeline emptied (a pending write is discarded); FSM enters CLEAR with clr_addr=0, so busy=1 immediately.
- FSM, two states:
  - CLEAR: one entry per cycle, mem[clr_addr]=INIT_VAL; clr_addr increments. The cycle that writes DEPTH-1 transitions to IDLE; busy=0 from the next cycle. A full clear takes DEPTH cycles.
  - IDLE: clear=1 moves to CLEAR next cycle with clr_addr=0. clear=1 while in CLEAR restarts from 0.
- While busy=1: write_enable and read_enable are ignored; d_valid stays 0.
- A write already in stage 2 when clear is accepted still commits before CLEAR starts.
- Write pipeline, 2 stages, one request accepted per cycle, no back-pressure:
  - Stage 1 (issue cycle t): capture address, data, mode; read the old entry.
  - Stage 2 (t+1): compute the result and commit it to memory at the t+1 edge.
  - Overwrite result = d_in.
  - Accumulate result = old + d_in, both sign-extended to DATA_W+1.
  - Default: wrap to DATA_W bits. ovf=1 in the commit cycle when the DATA_W+1 sum falls outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Forwarding: when stage 2 commits address A and stage 1 holds address A in the same cycle, stage 1 uses the stage-2 result as "old". Back-to-back accumulates to one address must sum exactly.
- Read: read_enable at cycle t gives d_out/d_valid at t+1 (latency 1).
  - The read reflects every write issued at <= t-1; the stage-2 result is forwarded if the address matches.
  - A write issued in the same cycle t is not visible.
  - d_out holds its last value when d_valid=0.
- Out-of-range address (>= DEPTH):
  - Write/accumulate: dropped, no memory change, ovf=0.
  - Read: returns 0 with d_valid=1.
- Simultaneous read and write to different addresses: both serviced with no interaction.

Optional Feature:
ACTION_RAM_SAT_EN
- Defined: accumulate saturates to 2^(DATA_W-1)-1 or -2^(DATA_W-1) on overflow; ovf still pulses.
- Undefined: accumulate wraps modulo 2^DATA_W; ovf still pulses.
- Overwrite is unaffected in both builds.

Test Plan:
- Release reset_n, DEPTH=16 -> busy=1 for exactly 16 cycles, then 0; reads of addr 0..15 all return INIT_VAL=0, d_valid one cycle after each read_enable.
- Overwrite addr 5 = 12, read addr 5 in the same cycle -> old value 0; read next cycle -> 12; read addr 5 one cycle later -> 12.
- Accumulate addr 3 with +10, +20, -5 on consecutive cycles, then read -> 25 (forwarding path); ovf never set.
- Overwrite addr 7 = 120, then accumulate +10:
  - Default build -> read -126, ovf pulses once.
  - With ACTION_RAM_SAT_EN -> read 127, ovf pulses once.
- Write addr 20 (DEPTH=16) = 9 -> no entry changes; read addr 20 -> d_out=0, d_valid=1.
- Assert clear mid-stream after writing addr 2 = 50 -> busy for 16 cycles, requests during busy ignored, addr 2 reads 0 afterward; pulse reset_n low mid-clear -> clear restarts from 0, full 16 cycles.
